fft_peak_reader: RTL

Output-side consumer for the in-place CoreFFT core in the GNSS acquisition path. It requests the result frame with READ_OUTP and captures each DATAO_VALID sample. It computes the squared magnitude of every bin and reports the largest bin and its index once per frame. Frames with too few or too many samples are flagged rather than reported.

---
 rtl/fft_peak_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_peak_reader.sv
// Result-side reader for the in-place FFT: streams a frame, finds the peak |X|^2 bin.
// Optional threshold detector is enabled with the FFT_PEAK_THRESH_EN macro.
module fft_peak_reader #(
  parameter int WIDTH  = 10,
  parameter int POINTS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef FFT_PEAK_THRESH_EN
  input  logic [2*WIDTH:0]            thresh,
  output logic                        peak_det,
`endif
  input  logic                        outp_ready,
  input  logic                        datao_valid,
  input  logic signed [WIDTH-1:0]     datao_re,
  input  logic signed [WIDTH-1:0]     datao_im,
  output logic                        read_outp,
  output logic                        busy,
  output logic                        peak_valid,
  output logic [2*WIDTH:0]            peak_mag,
  output logic [$clog2(POINTS)-1:0]   peak_idx,
  output logic                        frame_err,
  output logic [15:0]                 frame_cnt
);

  localparam int LOGPTS = $clog2(POINTS);
  localparam int MAGW   = 2*WIDTH+1;
  localparam int SQW    = 2*WIDTH;
  localparam logic [LOGPTS:0] CNT_FULL = (LOGPTS+1)'(POINTS);
  localparam logic [LOGPTS:0] CNT_SAT  = (LOGPTS+1)'(POINTS+1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, REPORT} state_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic               drain_q;
  logic [LOGPTS:0]    cnt_q;
  logic               take;
  logic               start;

  logic               vld_p1;
  logic [SQW-1:0]     sq_re_p1, sq_im_p1;
  logic [LOGPTS-1:0]  idx_p1;
  logic [MAGW-1:0]    sum_p1;
  logic [MAGW-1:0]    max_mag_p2;
  logic [LOGPTS-1:0]  max_idx_p2;

  // Most-negative input squares to 2^(2*WIDTH-2), still positive in SQW signed bits.
  function automatic logic [SQW-1:0] square(input logic signed [WIDTH-1:0] v);
    logic signed [SQW-1:0] p;
    p = SQW'(v) * SQW'(v);
    return p;
  endfunction

  function automatic logic [MAGW-1:0] mag_sum(input logic [SQW-1:0] a, input logic [SQW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign start  = (state_q == IDLE) && outp_ready;
  assign take   = (state_q == READ) && datao_valid && (cnt_q < CNT_FULL);
  assign sum_p1 = mag_sum(sq_re_p1, sq_im_p1);

  always_comb begin
    state_d   = state_q;
    read_outp = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    if (outp_ready) state_d = READ;
      READ: begin
        read_outp = 1'b1;
        if (ready_q && !outp_ready) state_d = DRAIN;
      end
      DRAIN:   if (drain_q) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      vld_p1     <= 1'b0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      peak_mag   <= '0;
      peak_idx   <= '0;
      frame_cnt  <= '0;
`ifdef FFT_PEAK_THRESH_EN
      peak_det   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= outp_ready;
      drain_q    <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      vld_p1     <= take;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      // Counter keeps running past POINTS so oversize frames are recognisable.
      if (start)
        cnt_q <= '0;
      else if ((state_q == READ) && datao_valid && (cnt_q != CNT_SAT))
        cnt_q <= cnt_q + (LOGPTS+1)'(1);
      if (state_q == REPORT) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (cnt_q == CNT_FULL) begin
          peak_valid <= 1'b1;
          peak_mag   <= max_mag_p2;
          peak_idx   <= max_idx_p2;
`ifdef FFT_PEAK_THRESH_EN
          peak_det   <= (max_mag_p2 > thresh);
`endif
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  // Stage 1: squares of the accepted sample
  always_ff @(posedge clk) begin
    if (take) begin
      sq_re_p1 <= square(datao_re);
      sq_im_p1 <= square(datao_im);
      idx_p1   <= cnt_q[LOGPTS-1:0];
    end
  end

  // Stage 2: sum and running max; strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (start) begin
      max_mag_p2 <= '0;
      max_idx_p2 <= '0;
    end else if (vld_p1 && ((idx_p1 == '0) || (sum_p1 > max_mag_p2))) begin
      max_mag_p2 <= sum_p1;
      max_idx_p2 <= idx_p1;
    end
  end

endmodule
